serial_bit_tx: RTL
==================

SERIAL_BIT_TX -- requirements
Module: serial_bit_tx

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the payload width in bits (legal values 1..16).
REQ-002 Parameter BIT_CYCLES, default 1, SHALL set the number of clk cycles each serial bit is held (legal values 1..255).
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port res  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 Port tx_data  input  DATA_W  SHALL carry the word to send; it is sampled only on handshake.
REQ-006 Port tx_valid  input  1  SHALL indicate that tx_data is valid.
REQ-007 Port tx_ready  output  1  SHALL be high only in state IDLE.
REQ-008 Port x_out  output  1  SHALL be the serial line; idle level is 1.
REQ-009 Port busy  output  1  SHALL be high in every state except IDLE.
REQ-010 Port done  output  1  SHALL be a one-cycle pulse in the first IDLE cycle after STOP.

Function
REQ-011 The block SHALL be a Moore FSM: x_out, tx_ready, busy and done are decoded from registered state only.
REQ-012 States SHALL be IDLE, START, DATA, PARITY and STOP, with PARITY present only per REQ-024.
REQ-013 A handshake SHALL occur when tx_valid=1 and tx_ready=1 at a rising edge; tx_data is then latched into a shift register and the FSM enters START.
REQ-014 x_out SHALL be 1 in IDLE and STOP, 0 in START, shift-register bit 0 in DATA (LSB first), and the parity bit in PARITY.
REQ-015 Each of START, each DATA bit, PARITY and STOP SHALL last exactly BIT_CYCLES cycles, timed by a bit counter that reloads on every state or bit change.
REQ-016 DATA SHALL shift right once per bit period and exit to PARITY or STOP after exactly DATA_W bits.
REQ-017 After STOP the FSM SHALL enter IDLE.
REQ-018 A minimum of one IDLE cycle SHALL separate consecutive frames, even when tx_valid is held high.
REQ-019 Latency: x_out SHALL fall to 0 in the first cycle after the handshake edge.
REQ-020 Changes on tx_valid or tx_data while busy=1 SHALL have no effect on the frame in progress.
REQ-021 Frame length SHALL be (DATA_W+2)*BIT_CYCLES cycles without parity and (DATA_W+3)*BIT_CYCLES cycles with parity.

Reset
REQ-022 When res=0 at a rising edge, the FSM SHALL go to IDLE, clear the shift register and bit counter, and drive x_out=1, tx_ready=1, busy=0, done=0, regardless of the current state.
REQ-023 A reset mid-frame SHALL abort the frame without a done pulse; the next handshake is accepted in the cycle after res returns to 1.

Configuration
REQ-024 Macro SERIAL_TX_PARITY_EN defined: the PARITY state SHALL be inserted between DATA and STOP, carrying even parity (XOR of all latched data bits). Macro undefined: DATA SHALL go directly to STOP, and no parity logic SHALL be compiled.

Structure
REQ-025 Package serial_tx_pkg SHALL hold the state enum typedef tx_state_t and the constant LINE_IDLE=1'b1.
REQ-026 Sub-module bit_timer SHALL implement the BIT_CYCLES down-counter with a load input and a terminal-count output.

Verification
REQ-027 DATA_W=8, BIT_CYCLES=1, no parity, send 8'hA5 -> x_out per cycle = 0,1,0,1,0,0,1,0,1,1; done pulses once; busy is high for 10 cycles.
REQ-028 SERIAL_TX_PARITY_EN, send 8'hA5 -> parity bit 0 follows the data bits; send 8'h07 -> parity bit 1; each frame is 11 cycles.
REQ-029 BIT_CYCLES=4, send 8'h01 -> x_out low for 4 cycles, high for 4, low for 28, high for 4; frame is 40 cycles.
REQ-030 tx_valid held high with 8'h3C then 8'hC3 -> two frames separated by exactly one IDLE cycle, with tx_ready high in that cycle.
REQ-031 res=0 during DATA bit 3 -> next edge gives x_out=1, tx_ready=1, busy=0, no done pulse; a new 8'hFF frame then sends correctly.
REQ-032 tx_data changed from 8'h55 to 8'hAA while busy -> the transmitted bits remain those of 8'h55.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial bit transmitter.
// SERIAL_TX_PARITY_EN adds the PARITY state and the even-parity helper.
package serial_tx_pkg;

    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_t;

`ifdef SERIAL_TX_PARITY_EN
    // Even parity over a zero-extended payload word.
    function automatic logic even_parity(input logic [15:0] word);
        return ^word;
    endfunction
`endif

endpackage

// File: rtl/bit_timer.sv
// Per-bit down-counter: load reloads BIT_CYCLES-1, tc flags the last cycle of a bit period.
module bit_timer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic res,
    input  logic load,
    output logic tc
);

    localparam logic [7:0] RELOAD = 8'(BIT_CYCLES - 1);

    logic [7:0] count_r;

    // Count down to zero and hold there until reloaded.
    always_ff @(posedge clk) begin
        if (!res) begin
            count_r <= 8'd0;
        end else if (load) begin
            count_r <= RELOAD;
        end else if (count_r != 8'd0) begin
            count_r <= count_r - 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == 8'd0);

endmodule

// File: rtl/serial_bit_tx.sv
// Serial transmitter: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Parity stage is built only when SERIAL_TX_PARITY_EN is defined.
module serial_bit_tx
    import serial_tx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              res,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              x_out,
    output logic              busy,
    output logic              done
);

    localparam logic [4:0] LAST_BIT = 5'(DATA_W - 1);

    tx_state_t         state_r, state_s;
    logic [DATA_W-1:0] shreg_r, shreg_s;
    logic [4:0]        bit_idx_r, bit_idx_s;
    logic              load_s, tc_s, line_s;
    logic              x_out_r, tx_ready_r, busy_r, done_r;
`ifdef SERIAL_TX_PARITY_EN
    logic              parity_r, parity_s;
`endif

    bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_bit_timer (
        .clk  (clk),
        .res  (res),
        .load (load_s),
        .tc   (tc_s)
    );

    // Next-state and datapath update; the timer reloads on every state or bit change.
    always_comb begin
        state_s   = state_r;
        shreg_s   = shreg_r;
        bit_idx_s = bit_idx_r;
        load_s    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parity_s  = parity_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (tx_valid) begin
                    state_s   = ST_START;
                    shreg_s   = tx_data;
                    bit_idx_s = 5'd0;
                    load_s    = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                    parity_s  = even_parity(16'(tx_data));
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tc_s) begin
                    state_s = ST_DATA;
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tc_s) begin
                    load_s = 1'b1;
                    if (bit_idx_r == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_s = ST_PARITY;
`else
                        state_s = ST_STOP;
`endif
                    end else begin
                        shreg_s   = shreg_r >> 1;
                        bit_idx_s = bit_idx_r + 5'd1;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                if (tc_s) begin
                    state_s = ST_STOP;
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (tc_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Line level for the upcoming state, so x_out is registered yet still Moore-decoded.
    always_comb begin
        line_s = LINE_IDLE;
        case (state_s)
            ST_START:  line_s = 1'b0;
            ST_DATA:   line_s = shreg_s[0];
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: line_s = parity_s;
`endif
            default:   line_s = LINE_IDLE;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (!res) begin
            state_r    <= ST_IDLE;
            shreg_r    <= '0;
            bit_idx_r  <= 5'd0;
            x_out_r    <= LINE_IDLE;
            tx_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            shreg_r    <= shreg_s;
            bit_idx_r  <= bit_idx_s;
            x_out_r    <= line_s;
            tx_ready_r <= (state_s == ST_IDLE);
            busy_r     <= (state_s != ST_IDLE);
            done_r     <= (state_r == ST_STOP) && (state_s == ST_IDLE);
`ifdef SERIAL_TX_PARITY_EN
            parity_r   <= parity_s;
`endif
        end
    end

    assign x_out    = x_out_r;
    assign tx_ready = tx_ready_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule
